// File: rtl/wb_sys_regs.sv
// Wishbone system register block: identity constants, free-running uptime, reloading
// countdown timer with sticky expiry and interrupt, and a byte-writable scratchpad.
module wb_sys_regs #(
    parameter int unsigned DEV_BASE_ADDR  = 0,
    parameter int unsigned DEV_HIGH_ADDR  = 'h1F,
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 8,
    parameter int unsigned NUM_SCRATCH    = 8,
    parameter logic [31:0] BOARD_ID       = 32'h0,
    parameter logic [31:0] REV_MAJ        = 32'h0,
    parameter logic [31:0] REV_MIN        = 32'h0,
    parameter logic [31:0] REV_RCS        = 32'h0
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [BUS_DATA_WIDTH/8-1:0] wbs_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic                        wbs_int_o
);
    localparam int unsigned NB = BUS_DATA_WIDTH / 8;

    typedef logic [BUS_DATA_WIDTH-1:0] word_t;

    localparam word_t C_BOARD_ID = word_t'(BOARD_ID);
    localparam word_t C_REV_MAJ  = word_t'(REV_MAJ);
    localparam word_t C_REV_MIN  = word_t'(REV_MIN);
    localparam word_t C_REV_RCS  = word_t'(REV_RCS);

    word_t       r_uptime;
    word_t       r_tload;
    word_t       r_tcount;
    word_t       r_dat;
    word_t       r_scratch [NUM_SCRATCH];
    logic [1:0]  r_ctrl;  // {int_en, timer_en}
    logic        r_expired;
    logic        r_ack;
    logic        r_err;
    logic        r_int;

    logic [31:0] w_off;
    logic        w_req;
    logic        w_mapped;
    logic        w_ro;
    logic        w_bad;
    logic        w_wr;
    logic        w_rd;
    logic        w_expire;
    word_t       w_rdata;
    word_t       w_tload_new;

    function automatic word_t f_merge(word_t i_old, word_t i_new, logic [NB-1:0] i_sel);
        word_t v;
        v = i_old;
        for (int b = 0; b < NB; b++) begin
            if (i_sel[b]) v[8*b +: 8] = i_new[8*b +: 8];
        end
        return v;
    endfunction

    // Modular subtraction folds the lower and upper window bounds into a single compare.
    always_comb begin
        w_off       = 32'(wbs_adr_i) - DEV_BASE_ADDR;
        w_req       = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err &
                      (w_off <= DEV_HIGH_ADDR - DEV_BASE_ADDR);
        w_mapped    = (w_off <= 32'(8 + NUM_SCRATCH));
        w_ro        = (w_off <= 32'd4) || (w_off == 32'd7);
        w_bad       = ~w_mapped | (wbs_we_i & w_ro);
        w_wr        = w_req & wbs_we_i & ~w_bad;
        w_rd        = w_req & ~wbs_we_i & ~w_bad;
        w_expire    = r_ctrl[0] & (r_tcount == '0);
        w_tload_new = f_merge(r_tload, wbs_dat_i, wbs_sel_i);
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            32'd0:   w_rdata = C_BOARD_ID;
            32'd1:   w_rdata = C_REV_MAJ;
            32'd2:   w_rdata = C_REV_MIN;
            32'd3:   w_rdata = C_REV_RCS;
            32'd4:   w_rdata = r_uptime;
            32'd5:   w_rdata = word_t'(r_ctrl);
            32'd6:   w_rdata = r_tload;
            32'd7:   w_rdata = r_tcount;
            32'd8:   w_rdata = word_t'(r_expired);
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (w_off == 32'(9 + i)) w_rdata = r_scratch[i];
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_uptime  <= '0;
            r_tload   <= '0;
            r_tcount  <= '0;
            r_dat     <= '0;
            r_ctrl    <= '0;
            r_expired <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_int     <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
        end else begin
            r_ack    <= w_req & ~w_bad;
            r_err    <= w_req & w_bad;
            r_dat    <= w_rd ? w_rdata : '0;
            r_int    <= r_expired & r_ctrl[1];
            r_uptime <= r_uptime + word_t'(1);

            if (w_wr && w_off == 32'd5 && wbs_sel_i[0]) begin
                r_ctrl <= wbs_dat_i[1:0];
                if (wbs_dat_i[2]) r_uptime <= '0;
            end

            // A load write overrides the countdown but does not suppress a coincident expiry.
            if (w_wr && w_off == 32'd6) begin
                r_tload  <= w_tload_new;
                r_tcount <= w_tload_new;
            end else if (r_ctrl[0]) begin
                r_tcount <= (r_tcount == '0) ? r_tload : r_tcount - word_t'(1);
            end

            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_wr && w_off == 32'd8 && wbs_sel_i[0] && wbs_dat_i[0]) begin
                r_expired <= 1'b0;
            end

            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_wr && w_off == 32'(9 + i)) begin
                    r_scratch[i] <= f_merge(r_scratch[i], wbs_dat_i, wbs_sel_i);
                end
            end
        end
    end

    assign wbs_dat_o = r_dat;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;
    assign wbs_int_o = r_int;

endmodule

// File: tb/tb_wb_sys_regs.sv
// Bench for wb_sys_regs: vector table, timer/handshake/reset sequences and randomized
// traffic, all checked every cycle against a register-level reference model.
module tb_wb_sys_regs;
    localparam int unsigned BASE = 'h20;
    localparam int unsigned HIGH = 'h3F;
    localparam int unsigned NS   = 8;
    localparam logic [31:0] BID  = 32'hCAFE0002;
    localparam logic [31:0] RMAJ = 32'h0000_0001;
    localparam logic [31:0] RMIN = 32'h0000_0002;
    localparam logic [31:0] RRCS = 32'h0000_00A5;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        int unsigned off;
        logic [31:0] dat;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, err, intr;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat_i, dat_o;
    logic        d_cyc, d_stb, d_we, d_ack, d_err, d_int;
    logic [7:0]  d_sel, d_adr;
    logic [63:0] d_dat_i, d_dat_o;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    logic [31:0] m_up = '0, m_load = '0, m_cnt = '0, m_dat = '0;
    logic        m_en = 1'b0, m_ie = 1'b0, m_exp = 1'b0;
    logic        m_ack = 1'b0, m_err = 1'b0, m_int = 1'b0;
    logic [31:0] m_scr [NS];

    always #5 clk = ~clk;

    wb_sys_regs #(
        .DEV_BASE_ADDR (BASE),
        .DEV_HIGH_ADDR (HIGH),
        .BUS_DATA_WIDTH(32),
        .BUS_ADDR_WIDTH(8),
        .NUM_SCRATCH   (NS),
        .BOARD_ID      (BID),
        .REV_MAJ       (RMAJ),
        .REV_MIN       (RMIN),
        .REV_RCS       (RRCS)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_dat_o(dat_o),
        .wbs_ack_o(ack),
        .wbs_err_o(err),
        .wbs_int_o(intr)
    );

    wb_sys_regs #(
        .BUS_DATA_WIDTH(64)
    ) dut64 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(d_cyc),
        .wbs_stb_i(d_stb),
        .wbs_we_i (d_we),
        .wbs_sel_i(d_sel),
        .wbs_adr_i(d_adr),
        .wbs_dat_i(d_dat_i),
        .wbs_dat_o(d_dat_o),
        .wbs_ack_o(d_ack),
        .wbs_err_o(d_err),
        .wbs_int_o(d_int)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    task automatic drive(input logic w, input logic [3:0] s, input int unsigned off,
                         input logic [31:0] d);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        sel   = s;
        adr   = 8'(BASE + off);
        dat_i = d;
    endtask

    task automatic idle();
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        sel   = 4'h0;
        adr   = 8'h00;
        dat_i = 32'h0;
    endtask

    // One clock: derive the model's next state from its register map and the applied
    // inputs, advance the clock, then compare every main-DUT output with the model.
    task automatic cycle(input string tag);
        logic [31:0] off, rd, msk, n_up, n_load, n_cnt, n_dat;
        logic        n_en, n_ie, n_exp, n_ack, n_err, n_int, acc, bad, expire;
        logic [31:0] n_scr [NS];
        off = 32'(adr) - BASE;
        for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{sel[b]}};
        rd = 32'h0;
        case (off)
            32'd0: rd = BID;
            32'd1: rd = RMAJ;
            32'd2: rd = RMIN;
            32'd3: rd = RRCS;
            32'd4: rd = m_up;
            32'd5: rd = {30'd0, m_ie, m_en};
            32'd6: rd = m_load;
            32'd7: rd = m_cnt;
            32'd8: rd = {31'd0, m_exp};
            default: if (off >= 9 && off < 9 + NS) rd = m_scr[int'(off) - 9];
        endcase
        acc = cyc && stb && !m_ack && !m_err && 32'(adr) >= BASE && 32'(adr) <= HIGH;
        bad = (off > 8 + NS) || (we && (off <= 4 || off == 7));
        n_scr = m_scr;
        if (rst) begin
            {n_up, n_load, n_cnt, n_dat} = '0;
            {n_en, n_ie, n_exp, n_ack, n_err, n_int} = '0;
            for (int i = 0; i < NS; i++) n_scr[i] = '0;
        end else begin
            n_ack  = acc && !bad;
            n_err  = acc && bad;
            n_dat  = (acc && !bad && !we) ? rd : 32'h0;
            n_int  = m_exp & m_ie;
            n_up   = m_up + 32'd1;
            n_en   = m_en;
            n_ie   = m_ie;
            n_load = m_load;
            expire = m_en && m_cnt == 0;
            n_cnt  = !m_en ? m_cnt : (m_cnt == 0 ? m_load : m_cnt - 32'd1);
            n_exp  = m_exp | expire;
            if (acc && !bad && we) begin
                case (off)
                    32'd5: if (sel[0]) begin
                        n_en = dat_i[0];
                        n_ie = dat_i[1];
                        if (dat_i[2]) n_up = 32'h0;
                    end
                    32'd6: begin
                        n_load = (m_load & ~msk) | (dat_i & msk);
                        n_cnt  = n_load;
                    end
                    32'd8: if (sel[0] && dat_i[0] && !expire) n_exp = 1'b0;
                    default: n_scr[int'(off) - 9] = (m_scr[int'(off) - 9] & ~msk) | (dat_i & msk);
                endcase
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        m_up = n_up; m_load = n_load; m_cnt = n_cnt; m_dat = n_dat;
        m_en = n_en; m_ie = n_ie; m_exp = n_exp; m_ack = n_ack; m_err = n_err; m_int = n_int;
        m_scr = n_scr;
        check(tag, 72'({ack, err, intr, dat_o}), 72'({m_ack, m_err, m_int, m_dat}));
    endtask

    task automatic xact(input logic w, input logic [3:0] s, input int unsigned off,
                        input logic [31:0] d, output logic [33:0] resp);
        drive(w, s, off, d);
        cycle("xact");
        resp = {ack, err, dat_o};
        idle();
        cycle("xact_idle");
    endtask

    initial begin
        vec_t        vt [17];
        logic [33:0] r;
        logic [2:0]  pat;
        logic        oow, p;
        int          last, rises;

        vt[0]  = '{1'b0, 4'hF, 0,  32'h0,          1'b1, 1'b0, BID};
        vt[1]  = '{1'b0, 4'hF, 1,  32'h0,          1'b1, 1'b0, RMAJ};
        vt[2]  = '{1'b0, 4'hF, 2,  32'h0,          1'b1, 1'b0, RMIN};
        vt[3]  = '{1'b0, 4'hF, 3,  32'h0,          1'b1, 1'b0, RRCS};
        vt[4]  = '{1'b1, 4'h5, 11, 32'h11223344,   1'b1, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 4'hF, 11, 32'h0,          1'b1, 1'b0, 32'h00220044};
        vt[6]  = '{1'b1, 4'hF, 0,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h0};
        vt[7]  = '{1'b0, 4'hF, 17, 32'h0,          1'b0, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 4'hF, 0,  32'h0,          1'b1, 1'b0, BID};
        vt[9]  = '{1'b1, 4'hF, 7,  32'h5,          1'b0, 1'b1, 32'h0};
        vt[10] = '{1'b1, 4'hF, 4,  32'h5,          1'b0, 1'b1, 32'h0};
        vt[11] = '{1'b0, 4'hF, 8,  32'h0,          1'b1, 1'b0, 32'h0};
        vt[12] = '{1'b1, 4'hF, 6,  32'h100,        1'b1, 1'b0, 32'h0};
        vt[13] = '{1'b0, 4'hF, 7,  32'h0,          1'b1, 1'b0, 32'h100};
        vt[14] = '{1'b1, 4'h0, 5,  32'h7,          1'b1, 1'b0, 32'h0};
        vt[15] = '{1'b0, 4'hF, 5,  32'h0,          1'b1, 1'b0, 32'h0};
        vt[16] = '{1'b0, 4'hF, 11, 32'h0,          1'b1, 1'b0, 32'h00220044};

        for (int i = 0; i < NS; i++) m_scr[i] = '0;
        rst = 1'b1;
        idle();
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_sel = 8'h0; d_adr = 8'h0; d_dat_i = 64'h0;
        repeat (3) cycle("reset");
        check("reset_outputs", 72'({ack, err, intr, dat_o}), 72'h0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            xact(vt[i].we, vt[i].sel, vt[i].off, vt[i].dat, r);
            check($sformatf("vec%0d", i), 72'(r), 72'({vt[i].ack, vt[i].err, vt[i].rdat}));
        end

        drive(1'b0, 4'hF, 0, 32'h0);
        pat = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cycle("held");
            pat[2 - k] = ack;
        end
        idle();
        cycle("held_end");
        check("held_stb_acks", 72'(pat), 72'(3'b101));

        oow = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc = 1'b1; stb = 1'b1; we = (k % 2) == 1; sel = 4'hF; dat_i = 32'hFFFF_FFFF;
            adr = (k < 3) ? 8'h1F : 8'h40;
            cycle("oow");
            oow = oow | ack | err;
        end
        idle();
        cycle("oow_end");
        check("oow_no_response", 72'(oow), 72'(1'b0));

        xact(1'b1, 4'hF, 6, 32'd3, r);
        xact(1'b1, 4'hF, 5, 32'd3, r);
        p = intr;
        last = -1;
        rises = 0;
        for (int k = 0; k < 26; k++) begin
            if (intr && !p) begin
                if (last >= 0) check("int_period", 72'(cyc_n - last), 72'(4));
                last = cyc_n;
                rises++;
                drive(1'b1, 4'h1, 8, 32'h1);
            end else begin
                idle();
            end
            p = intr;
            cycle("timer");
        end
        check("int_rise_count", 72'(rises >= 5), 72'(1'b1));

        xact(1'b1, 4'hF, 5, 32'd2, r);
        xact(1'b1, 4'h1, 8, 32'd1, r);
        repeat (2) cycle("settle");
        check("int_cleared", 72'(intr), 72'(1'b0));
        xact(1'b1, 4'hF, 6, 32'd3, r);
        drive(1'b1, 4'hF, 5, 32'd3);
        cycle("ctrl_on");
        idle();
        repeat (5) cycle("count");
        check("first_expiry_int", 72'(intr), 72'(1'b1));
        drive(1'b1, 4'h1, 8, 32'h1);
        cycle("w1c");
        idle();
        cycle("w1c_wait");
        check("w1c_int_low", 72'(intr), 72'(1'b0));
        drive(1'b1, 4'h1, 8, 32'h1);
        cycle("w1c_coinc");
        idle();
        cycle("coinc_wait");
        check("coinc_int_high", 72'(intr), 72'(1'b1));
        xact(1'b0, 4'hF, 8, 32'h0, r);
        check("coinc_status", 72'(r), 72'({1'b1, 1'b0, 32'h1}));

        drive(1'b1, 4'hF, 12, 32'hFFFF_FFFF);
        rst = 1'b1;
        cycle("rst_mid_write");
        check("rst_outputs", 72'({ack, err, intr, dat_o}), 72'h0);
        rst = 1'b0;
        drive(1'b0, 4'hF, 4, 32'h0);
        cycle("uptime_restart");
        check("uptime_restart", 72'({ack, err, dat_o}), 72'({1'b1, 1'b0, 32'h0}));
        idle();
        cycle("post_rst");
        xact(1'b0, 4'hF, 12, 32'h0, r);
        check("scratch_after_rst", 72'(r), 72'({1'b1, 1'b0, 32'h0}));

        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 8'hFF; d_adr = 8'd11;
        d_dat_i = 64'h1122334455667788;
        cycle("w64");
        check("w64_write_ack", 72'({d_ack, d_err}), 72'(2'b10));
        d_cyc = 1'b0; d_stb = 1'b0;
        cycle("w64");
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0;
        cycle("w64");
        check("w64_read", 72'({d_ack, d_err, d_dat_o}), 72'({1'b1, 1'b0, 64'h1122334455667788}));
        d_cyc = 1'b0; d_stb = 1'b0;
        cycle("w64");
        check("w64_dat_zero", 72'({d_ack, d_dat_o}), 72'h0);

        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc = ($urandom_range(0, 3) != 0);
            stb = ($urandom_range(0, 2) != 0);
            we  = ($urandom_range(0, 1) == 1);
            sel = 4'($urandom);
            if ($urandom_range(0, 3) != 0) adr = 8'(BASE + $urandom_range(0, 16));
            else adr = 8'($urandom_range(8'h1C, 8'h43));
            if (32'(adr) == BASE + 6) dat_i = 32'($urandom_range(0, 6));
            else if (32'(adr) == BASE + 5 && $urandom_range(0, 1) == 1) dat_i = 32'h3;
            else dat_i = $urandom;
            cycle("random");
        end
        rst = 1'b0;
        idle();
        cycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_sys_regs.md
WB_SYS_REGS -- requirements
Module: wb_sys_regs

Interface
REQ-001 The block SHALL have parameter DEV_BASE_ADDR, default 0, meaning first bus address decoded.
REQ-002 The block SHALL have parameter DEV_HIGH_ADDR, default 'h1F, meaning last bus address decoded (inclusive).
REQ-003 The block SHALL have parameter BUS_DATA_WIDTH, default 32, meaning data width; legal values are 8, 16, 32 or 64.
REQ-004 The block SHALL have parameter BUS_ADDR_WIDTH, default 8, meaning word-address width.
REQ-005 The block SHALL have parameter NUM_SCRATCH, default 8, meaning scratchpad word count, 1..16.
REQ-006 The block SHALL have parameters BOARD_ID, REV_MAJ, REV_MIN and REV_RCS, each default 32'h0, meaning read-only identity constants.
REQ-007 Ports, in this order: wb_clk_i in 1 clock; wb_rst_i in 1 reset; wbs_cyc_i in 1; wbs_stb_i in 1; wbs_we_i in 1; wbs_sel_i in BUS_DATA_WIDTH/8 byte enables; wbs_adr_i in BUS_ADDR_WIDTH; wbs_dat_i in BUS_DATA_WIDTH; wbs_dat_o out BUS_DATA_WIDTH; wbs_ack_o out 1; wbs_err_o out 1; wbs_int_o out 1.
REQ-008 The block SHALL use one clock, wb_clk_i; reset wb_rst_i SHALL be synchronous and active-high.

Function
REQ-009 The block SHALL accept a request when cyc&stb are high, DEV_BASE_ADDR<=adr<=DEV_HIGH_ADDR, and both ack_o and err_o are low; off = adr-DEV_BASE_ADDR.
REQ-010 The block SHALL assert exactly one of ack_o/err_o for exactly one cycle, in the cycle after acceptance (latency 1); a request held over multiple cycles SHALL yield one response per acceptance.
REQ-011 Out-of-window addresses SHALL get no response and no state change.
REQ-012 Map (RO = read-only): 0 BOARD_ID RO; 1 REV_MAJ RO; 2 REV_MIN RO; 3 REV_RCS RO; 4 UPTIME RO; 5 CONTROL RW; 6 TIMER_LOAD RW; 7 TIMER_COUNT RO; 8 STATUS W1C; 9..8+NUM_SCRATCH SCRATCH[0..NUM_SCRATCH-1] RW.
REQ-013 Writes to RO offsets and any access to unmapped in-window offsets SHALL return err_o, with no state change; reads of mapped offsets and writes to RW/W1C offsets SHALL return ack_o.
REQ-014 Constants SHALL be truncated or zero-extended to BUS_DATA_WIDTH; unused register bits SHALL read 0.
REQ-015 RW writes SHALL update only bytes whose wbs_sel_i bit is 1.
REQ-016 wbs_dat_o SHALL carry read data in the ack cycle and SHALL be 0 in every other cycle, including err cycles.
REQ-017 UPTIME SHALL increment by 1 every cycle, wrapping modulo 2^BUS_DATA_WIDTH.
REQ-018 CONTROL bit0 timer_en, bit1 int_en and bit2 uptime_clr SHALL be defined; uptime_clr SHALL be self-clearing, zero UPTIME in the next cycle, and always read 0.
REQ-019 Writing TIMER_LOAD SHALL also load TIMER_COUNT with the written value in the same clock edge.
REQ-020 With timer_en=1 and TIMER_COUNT>0, TIMER_COUNT SHALL decrement each cycle; at 0 it SHALL reload TIMER_LOAD and set STATUS bit0 (expired), giving period TIMER_LOAD+1.
REQ-021 With timer_en=0, TIMER_COUNT SHALL hold.
REQ-022 With TIMER_LOAD=0 and timer_en=1, expired SHALL set every cycle.
REQ-023 A STATUS write with sel[0]=1 and dat[0]=1 SHALL clear expired, except that a same-cycle expiry SHALL win and expired SHALL stay 1.
REQ-024 wbs_int_o SHALL be registered and equal to expired & int_en, one cycle after either changes.
REQ-025 A TIMER_LOAD write in the same cycle as expiry SHALL load the written value, and expired SHALL still set.

Reset
REQ-026 While wb_rst_i is high, wbs_dat_o, ack_o, err_o, int_o, UPTIME, CONTROL, TIMER_LOAD, TIMER_COUNT, STATUS and all SCRATCH SHALL be 0.
REQ-027 A transaction accepted in the cycle reset asserts SHALL get no response and cause no write.
REQ-028 The first acceptance after reset SHALL be possible in the first cycle reset is low.

Verification
REQ-029 The bench SHALL cover: read offsets 0-3 with BOARD_ID=32'hCAFE0002 -> ack one cycle later, dat_o=32'hCAFE0002 then 0 the following cycle.
REQ-030 The bench SHALL cover: write SCRATCH[2]=32'h11223344 sel=4'b0101, then read -> 32'h00220044; BUS_DATA_WIDTH=64 rerun with sel=8'hFF -> full word.
REQ-031 The bench SHALL cover: write offset 0, and read offset 9+NUM_SCRATCH (within window) -> err_o one cycle, ack_o 0, no register changes.
REQ-032 The bench SHALL cover: TIMER_LOAD=3, CONTROL=3 -> expired and int_o rise every 4 cycles; W1C STATUS -> int_o low next cycle unless coincident with expiry.
REQ-033 The bench SHALL cover: stb held 3 cycles on one read -> responses spaced every 2 cycles; out-of-window stb -> none.
REQ-034 The bench SHALL cover: reset mid-write -> target SCRATCH unchanged (0), all outputs 0, UPTIME restarts at 0.
